// File: rtl/npu_host_port.sv
// npu_host_port: NPU-side responder on the shared host bus. It parses a
// six-word configuration header, streams weights and inputs into the core,
// starts the core, and returns results on the bus during readout.
module npu_host_port #(
   parameter int DW = 32,
   parameter int NW = 5,
   parameter int WW = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          we,
   input  logic          oe,
   inout  wire  [DW-1:0] data,
   output logic          ready,
   output logic          err,
   output logic [1:0]    cfg_layers,
   output logic [NW-1:0] cfg_in,
   output logic [NW-1:0] cfg_h1,
   output logic [NW-1:0] cfg_h2,
   output logic [NW-1:0] cfg_out,
   output logic [1:0]    cfg_act,
   output logic          wgt_wr,
   output logic [WW-1:0] wgt_idx,
   output logic [DW-1:0] wgt_data,
   output logic          in_wr,
   output logic [NW-1:0] in_idx,
   output logic [DW-1:0] in_data,
   output logic          core_start,
   input  logic          core_done,
   output logic [NW-1:0] res_idx,
   input  logic [DW-1:0] res_data
);

   typedef enum logic [2:0] {S_IDLE, S_CFG, S_WGT, S_INP, S_BUSY, S_DONE} state_t;

   localparam logic [WW-1:0] ONE = WW'(1);
   localparam logic [WW-1:0] TWO = WW'(2);

   state_t        r_state, w_stateNext;
   logic          r_wePrev;
   logic [WW-1:0] r_cnt, r_wgtTotal, w_wgtTotal;
   logic [WW-1:0] w_in, w_h1, w_h2, w_out;
   logic          r_ready, r_err, r_wgtWr, r_inWr, r_coreStart;
   logic [1:0]    r_cfgLayers, r_cfgAct;
   logic [NW-1:0] r_cfgIn, r_cfgH1, r_cfgH2, r_cfgOut, r_inIdx, r_resIdx;
   logic [WW-1:0] r_wgtIdx;
   logic [DW-1:0] r_wgtData, r_inData;
   logic          w_header, w_setErr, w_clearTxn, w_cfgWord, w_wgtWord, w_inWord;
   logic          w_coreStart, w_toDone, w_readWord, w_lastRead, w_drive;

   assign ready      = r_ready;
   assign err        = r_err;
   assign cfg_layers = r_cfgLayers;
   assign cfg_in     = r_cfgIn;
   assign cfg_h1     = r_cfgH1;
   assign cfg_h2     = r_cfgH2;
   assign cfg_out    = r_cfgOut;
   assign cfg_act    = r_cfgAct;
   assign wgt_wr     = r_wgtWr;
   assign wgt_idx    = r_wgtIdx;
   assign wgt_data   = r_wgtData;
   assign in_wr      = r_inWr;
   assign in_idx     = r_inIdx;
   assign in_data    = r_inData;
   assign core_start = r_coreStart;
   assign res_idx    = r_resIdx;

   // A header is the first write cycle after a non-write cycle.
   assign w_header = we && !r_wePrev;

   // Results go on the bus only in DONE while the host reads and is not writing.
   assign w_drive = (r_state == S_DONE) && oe && !we;
   assign data    = w_drive ? res_data : {DW{1'bz}};

   assign w_in  = WW'(r_cfgIn);
   assign w_h1  = WW'(r_cfgH1);
   assign w_h2  = WW'(r_cfgH2);
   assign w_out = WW'(r_cfgOut);

   // Weight count: (n_src+1)*n_dst summed over the layer chain, with n = field+1.
   always_comb begin
      w_wgtTotal = '0;
      case (r_cfgLayers)
         2'd0: w_wgtTotal = (w_in + TWO) * (w_out + ONE);
         2'd1: w_wgtTotal = (w_in + TWO) * (w_h1 + ONE) + (w_h1 + TWO) * (w_out + ONE);
         2'd2: w_wgtTotal = (w_in + TWO) * (w_h1 + ONE) + (w_h1 + TWO) * (w_h2 + ONE)
                          + (w_h2 + TWO) * (w_out + ONE);
         default: w_wgtTotal = '0;
      endcase
   end

   // Next-state logic and per-cycle control decisions for the transaction phases.
   always_comb begin
      w_stateNext = r_state;
      w_setErr    = 1'b0;
      w_clearTxn  = 1'b0;
      w_cfgWord   = 1'b0;
      w_wgtWord   = 1'b0;
      w_inWord    = 1'b0;
      w_coreStart = 1'b0;
      w_toDone    = 1'b0;
      w_readWord  = 1'b0;
      w_lastRead  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_header) begin
               w_clearTxn  = 1'b1;
               w_stateNext = S_CFG;
            end
         end
         S_CFG: begin
            if (!we) begin
               w_setErr    = 1'b1;
               w_stateNext = S_IDLE;
            end else begin
               w_cfgWord = 1'b1;
               if (r_cnt == '0 && data[1:0] == 2'd3) begin
                  w_setErr    = 1'b1;
                  w_stateNext = S_IDLE;
               end else if (r_cnt == WW'(5)) begin
                  w_stateNext = S_WGT;
               end
            end
         end
         S_WGT: begin
            if (!we) begin
               w_setErr    = 1'b1;
               w_stateNext = S_IDLE;
            end else begin
               w_wgtWord = 1'b1;
               if (r_cnt == r_wgtTotal - ONE) w_stateNext = S_INP;
            end
         end
         S_INP: begin
            if (!we) begin
               w_setErr    = 1'b1;
               w_stateNext = S_IDLE;
            end else begin
               w_inWord = 1'b1;
               if (r_cnt == w_in) begin
                  w_coreStart = 1'b1;
                  w_stateNext = S_BUSY;
               end
            end
         end
         S_BUSY: begin
            if (we) w_setErr = 1'b1;
            if (core_done) begin
               w_toDone    = 1'b1;
               w_stateNext = S_DONE;
            end
         end
         S_DONE: begin
            if (w_header) begin
               w_clearTxn  = 1'b1;
               w_stateNext = S_CFG;
            end else if (we) begin
               w_setErr = 1'b1;
            end else if (oe) begin
               w_readWord = 1'b1;
               if (r_resIdx == r_cfgOut) begin
                  w_lastRead  = 1'b1;
                  w_stateNext = S_IDLE;
               end
            end
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_stateNext;
   end

   // Datapath: counters, configuration fields, strobes, status flags and readout index.
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_wePrev    <= 1'b0;
         r_cnt       <= '0;
         r_wgtTotal  <= '0;
         r_ready     <= 1'b0;
         r_err       <= 1'b0;
         r_wgtWr     <= 1'b0;
         r_inWr      <= 1'b0;
         r_coreStart <= 1'b0;
         r_cfgLayers <= '0;
         r_cfgAct    <= '0;
         r_cfgIn     <= '0;
         r_cfgH1     <= '0;
         r_cfgH2     <= '0;
         r_cfgOut    <= '0;
         r_inIdx     <= '0;
         r_resIdx    <= '0;
         r_wgtIdx    <= '0;
         r_wgtData   <= '0;
         r_inData    <= '0;
      end else begin
         r_wePrev    <= we;
         r_wgtWr     <= w_wgtWord;
         r_inWr      <= w_inWord;
         r_coreStart <= w_coreStart;
         if (w_stateNext != r_state)                r_cnt <= '0;
         else if (w_cfgWord || w_wgtWord || w_inWord) r_cnt <= r_cnt + ONE;
         if (w_setErr)        r_err <= 1'b1;
         else if (w_clearTxn) r_err <= 1'b0;
         if (w_clearTxn || w_toDone) begin
            r_ready  <= w_toDone;
            r_resIdx <= '0;
         end else if (w_readWord) begin
            r_resIdx <= w_lastRead ? '0 : r_resIdx + 1'b1;
            if (w_lastRead) r_ready <= 1'b0;
         end
         if (w_cfgWord) begin
            case (r_cnt[2:0])
               3'd0: if (data[1:0] != 2'd3) r_cfgLayers <= data[1:0];
               3'd1: r_cfgIn  <= data[NW-1:0];
               3'd2: r_cfgH1  <= data[NW-1:0];
               3'd3: r_cfgH2  <= data[NW-1:0];
               3'd4: r_cfgOut <= data[NW-1:0];
               3'd5: begin
                  r_cfgAct   <= data[1:0];
                  r_wgtTotal <= w_wgtTotal;
               end
               default: ;
            endcase
         end
         if (w_wgtWord) begin
            r_wgtIdx  <= r_cnt;
            r_wgtData <= data;
         end
         if (w_inWord) begin
            r_inIdx  <= r_cnt[NW-1:0];
            r_inData <= data;
         end
      end
   end

endmodule

// File: tb/tb_npu_host_port.sv
// tb_npu_host_port: directed self-checking bench for npu_host_port.
module tb_npu_host_port;

   logic        clk, rst, we, oe, core_done;
   logic [31:0] tbData;
   wire  [31:0] data;
   logic        ready, err, wgt_wr, in_wr, core_start;
   logic [1:0]  cfg_layers, cfg_act;
   logic [4:0]  cfg_in, cfg_h1, cfg_h2, cfg_out, in_idx, res_idx;
   logic [11:0] wgt_idx;
   logic [31:0] wgt_data, in_data, res_data;
   int          checkCount;
   int          errorCount;

   // Host side of the shared bus: drives only while writing.
   assign data = we ? tbData : 'z;

   // Result memory seen by the port: a fixed pattern per address.
   assign res_data = 32'hC0DE_0000 + {27'd0, res_idx} * 32'd3 + 32'd7;

   npu_host_port #(.DW(32), .NW(5), .WW(12)) dut (
      .clk(clk), .rst(rst), .we(we), .oe(oe), .data(data),
      .ready(ready), .err(err), .cfg_layers(cfg_layers),
      .cfg_in(cfg_in), .cfg_h1(cfg_h1), .cfg_h2(cfg_h2), .cfg_out(cfg_out),
      .cfg_act(cfg_act), .wgt_wr(wgt_wr), .wgt_idx(wgt_idx), .wgt_data(wgt_data),
      .in_wr(in_wr), .in_idx(in_idx), .in_data(in_data),
      .core_start(core_start), .core_done(core_done),
      .res_idx(res_idx), .res_data(res_data)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] resExp(input int k);
      return 32'hC0DE_0000 + 32'(k) * 32'd3 + 32'd7;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one bus cycle, then land 1 time unit after the sampling edge.
   task automatic applyStimulus(input logic weV, input logic oeV, input logic [31:0] d);
      we     = weV;
      oe     = oeV;
      tbData = d;
      @(posedge clk);
      #1;
   endtask

   task automatic sendHeader(input bit leadIdle);
      if (leadIdle) applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'hFFFF_FFFF);
      checkOutput("hdrErrClear", err, 0);
      checkOutput("hdrReadyClear", ready, 0);
   endtask

   task automatic sendConfig(input int l, input int i, input int h1, input int h2,
                             input int o, input int a);
      applyStimulus(1'b1, 1'b0, 32'(l));
      applyStimulus(1'b1, 1'b0, 32'(i));
      applyStimulus(1'b1, 1'b0, 32'(h1));
      applyStimulus(1'b1, 1'b0, 32'(h2));
      applyStimulus(1'b1, 1'b0, 32'(o));
      applyStimulus(1'b1, 1'b0, 32'(a));
      checkOutput("cfgWgtQuiet", wgt_wr, 0);
      checkOutput("cfgLayers", cfg_layers, 32'(l));
      checkOutput("cfgIn", cfg_in, 32'(i));
      if (l >= 1) checkOutput("cfgH1", cfg_h1, 32'(h1));
      if (l >= 2) checkOutput("cfgH2", cfg_h2, 32'(h2));
      checkOutput("cfgOut", cfg_out, 32'(o));
      checkOutput("cfgAct", cfg_act, 32'(a));
   endtask

   task automatic streamData(input int nW, input int nI, input bit extra);
      for (int w = 0; w < nW; w++) begin
         applyStimulus(1'b1, 1'b0, 32'h1000 + 32'(w));
         checkOutput("wgtWr", wgt_wr, 1);
         checkOutput("wgtIdx", wgt_idx, 32'(w));
         checkOutput("wgtData", wgt_data, 32'h1000 + 32'(w));
         checkOutput("wgtNoIn", in_wr, 0);
      end
      for (int i = 0; i < nI; i++) begin
         applyStimulus(1'b1, 1'b0, 32'h2000 + 32'(i));
         checkOutput("inWr", in_wr, 1);
         checkOutput("inIdx", in_idx, 32'(i));
         checkOutput("inData", in_data, 32'h2000 + 32'(i));
         checkOutput("inNoWgt", wgt_wr, 0);
         checkOutput("coreStart", core_start, (i == nI - 1) ? 1 : 0);
      end
      if (extra) begin
         applyStimulus(1'b1, 1'b0, 32'hDEAD);
         checkOutput("extraNoIn", in_wr, 0);
         checkOutput("extraErr", err, 1);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("startPulseOnce", core_start, 0);
      if (!extra) checkOutput("noErr", err, 0);
   endtask

   task automatic completeCore();
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("busyNotReady", ready, 0);
      core_done = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      core_done = 1'b0;
      checkOutput("readyRise", ready, 1);
      checkOutput("resIdxStart", res_idx, 0);
   endtask

   task automatic readResults(input int nOut);
      for (int k = 0; k < nOut; k++) begin
         we = 1'b0;
         oe = 1'b1;
         #1;
         checkOutput("resIdx", res_idx, 32'(k));
         checkOutput("resData", data, resExp(k));
         @(posedge clk);
         #1;
         oe = 1'b0;
         if (k < nOut - 1) begin
            checkOutput("readyHeld", ready, 1);
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("gapIdx", res_idx, 32'(k + 1));
         end else begin
            checkOutput("readyFall", ready, 0);
         end
      end
   endtask

   // Directed scenario sequence.
   initial begin
      checkCount = 0;
      errorCount = 0;
      rst = 1'b0;
      core_done = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b1, 32'h0);
      checkOutput("rstReady", ready, 0);
      checkOutput("rstErr", err, 0);
      checkOutput("rstCfg", {cfg_layers, cfg_in, cfg_h1, cfg_h2, cfg_out, cfg_act}, 0);
      checkOutput("rstStrobes", {wgt_wr, in_wr, core_start}, 0);
      checkOutput("rstIdx", {wgt_idx, in_idx, res_idx}, 0);
      checkOutput("rstWData", wgt_data, 0);
      checkOutput("rstIData", in_data, 0);
      checkOutput("rstHiZ", data === res_data, 0);
      rst = 1'b1;

      // Single-layer transaction with full readout.
      sendHeader(1);
      sendConfig(0, 9, 0, 0, 0, 0);
      streamData(11, 10, 0);
      completeCore();
      readResults(1);

      // Same transaction again, stopped in DONE for a write/read clash.
      sendHeader(1);
      sendConfig(0, 9, 0, 0, 0, 0);
      streamData(11, 10, 0);
      completeCore();
      we = 1'b1;
      oe = 1'b1;
      tbData = 32'h5555_AAAA;
      #1;
      checkOutput("busWeWins", data, 32'h5555_AAAA);
      @(posedge clk);
      #1;
      checkOutput("clashHdrReady", ready, 0);

      // One hidden layer: 58 weights, extra word, two result words with a gap.
      sendConfig(1, 3, 7, 0, 1, 2);
      streamData(58, 4, 1);
      completeCore();
      readResults(2);

      // Back-to-back header immediately after IDLE; sequence repeats identically.
      sendHeader(0);
      sendConfig(0, 9, 0, 0, 0, 0);
      streamData(11, 10, 0);
      completeCore();
      readResults(1);

      // Two hidden layers: 3*3 + 4*1 + 2*1 = 15 weights.
      sendHeader(1);
      sendConfig(2, 1, 2, 0, 0, 1);
      streamData(15, 2, 0);
      completeCore();
      readResults(1);

      // Early we drop after weight 5.
      sendHeader(1);
      sendConfig(0, 9, 0, 0, 0, 0);
      for (int w = 0; w < 6; w++) applyStimulus(1'b1, 1'b0, 32'h1000 + 32'(w));
      checkOutput("dropLastWgt", wgt_idx, 5);
      applyStimulus(1'b0, 1'b0, 32'h0);
      checkOutput("dropErr", err, 1);
      checkOutput("dropNoWgt", wgt_wr, 0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus(1'b0, 1'b0, 32'h0);
         checkOutput("dropNoStart", core_start, 0);
         checkOutput("dropErrSticky", err, 1);
      end
      oe = 1'b1;
      #1;
      checkOutput("oeIdleHiZ", data === res_data, 0);
      @(posedge clk);
      #1;
      checkOutput("oeIdleNoAdv", res_idx, 0);
      oe = 1'b0;

      // Bad layer count right after a header that clears the previous error.
      sendHeader(0);
      applyStimulus(1'b1, 1'b0, 32'h3);
      checkOutput("badLayersErr", err, 1);
      for (int c = 0; c < 7; c++) begin
         applyStimulus(1'b1, 1'b0, 32'h0000_0010 + 32'(c));
         checkOutput("badNoWgt", wgt_wr, 0);
         checkOutput("badNoIn", in_wr, 0);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);

      // Reset in the middle of weight streaming.
      sendHeader(1);
      sendConfig(0, 9, 0, 0, 0, 0);
      for (int w = 0; w < 3; w++) applyStimulus(1'b1, 1'b0, 32'h1000 + 32'(w));
      rst = 1'b0;
      applyStimulus(1'b1, 1'b0, 32'h1003);
      checkOutput("midRstStrobes", {wgt_wr, in_wr, core_start, ready, err}, 0);
      checkOutput("midRstIdx", {wgt_idx, in_idx, res_idx}, 0);
      checkOutput("midRstCfg", {cfg_layers, cfg_in, cfg_h1, cfg_h2, cfg_out, cfg_act}, 0);
      checkOutput("midRstWData", wgt_data, 0);
      rst = 1'b1;
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b0, 32'h1004);
      checkOutput("postRstNoWgt", wgt_wr, 0);
      applyStimulus(1'b0, 1'b0, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
